// File: rtl/rotary_valve_seq_if.sv
// Control/status bundle between the run controller and the rotary valve sequencer.
// Every cb* line is a valve: 1 = pressurised (closed), 0 = open.
interface rotary_valve_seq_if;
   logic       start;
   logic       abort;
   logic [1:0] port_sel;
   logic [1:0] trap_sel;
   logic       busy;
   logic       done;
   logic       aborted;
   logic       cb1_1, cb1_2, cb2_1, cb2_2;
   logic       cb3_1, cb3_2, cb3_3;
   logic       cb4_1, cb4_2;
   logic       cb6_2, cb5_1, cb5_2, cb6_1;

   modport master (
      output start, abort, port_sel, trap_sel,
      input  busy, done, aborted,
      input  cb1_1, cb1_2, cb2_1, cb2_2, cb3_1, cb3_2, cb3_3, cb4_1, cb4_2,
      input  cb6_2, cb5_1, cb5_2, cb6_1
   );

   modport slave (
      input  start, abort, port_sel, trap_sel,
      output busy, done, aborted,
      output cb1_1, cb1_2, cb2_1, cb2_2, cb3_1, cb3_2, cb3_3, cb4_1, cb4_2,
      output cb6_2, cb5_1, cb5_2, cb6_1
   );
endinterface

// File: rtl/rotary_valve_seq.sv
// Load / mix / flush / settle sequencer driving the 13 valve lines of the rotary mixer chip.
// All valve outputs are registered and close (go to 1) asynchronously on reset.
module rotary_valve_seq #(
   parameter int unsigned TICK_DIV     = 4,
   parameter int unsigned LOAD_TICKS   = 200,
   parameter int unsigned PHASE_TICKS  = 10,
   parameter int unsigned MIX_ROUNDS   = 50,
   parameter int unsigned FLUSH_TICKS  = 300,
   parameter int unsigned SETTLE_TICKS = 5,
   parameter int unsigned CNT_W        = 16
) (
   input logic              clk,
   input logic              rst,
   rotary_valve_seq_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StLoad, StSet1, StMix, StSet2, StFlush, StSet3, StFin
   } state_e;

   localparam logic [CNT_W-1:0] One        = CNT_W'(1);
   localparam logic [CNT_W-1:0] TickLast   = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] LoadLast   = CNT_W'(LOAD_TICKS - 1);
   localparam logic [CNT_W-1:0] PhaseLast  = CNT_W'(PHASE_TICKS - 1);
   localparam logic [CNT_W-1:0] RoundLast  = CNT_W'(MIX_ROUNDS - 1);
   localparam logic [CNT_W-1:0] FlushLast  = CNT_W'(FLUSH_TICKS - 1);
   localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_TICKS - 1);

   // Bit positions inside valve_q.
   localparam int unsigned Cb11 = 12, Cb12 = 11, Cb21 = 10, Cb22 = 9;
   localparam int unsigned Cb31 = 8, Cb32 = 7, Cb33 = 6, Cb41 = 5, Cb42 = 4;
   localparam int unsigned Cb51 = 3, Cb52 = 2, Cb61 = 1, Cb62 = 0;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] ptick_q, ptick_d;
   logic [CNT_W-1:0] round_q, round_d;
   logic [1:0]       phase_q, phase_d;
   logic [1:0]       port_q, port_d, trap_q, trap_d;
   logic             abrt_q, abrt_d;
   logic [12:0]      valve_q, valve_d;
   logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
   logic             tick, mix_end, abort_hit, settle_end;

   assign tick       = (pre_q == TickLast);
   assign settle_end = tick && (cnt_q == SettleLast);
   assign mix_end    = tick && (ptick_q == PhaseLast) && (phase_q == 2'd2) &&
                       (round_q == RoundLast);
   assign abort_hit  = bus.abort && (state_q != StIdle) && (state_q != StFin);

   always_comb begin
      state_d = state_q;
      pre_d   = tick ? '0 : pre_q + One;
      cnt_d   = tick ? cnt_q + One : cnt_q;
      ptick_d = ptick_q;
      phase_d = phase_q;
      round_d = round_q;
      abrt_d  = abrt_q;
      port_d  = port_q;
      trap_d  = trap_q;

      // The peristaltic loop keeps stepping through both MIX and FLUSH.
      if (tick && (state_q == StMix || state_q == StFlush)) begin
         if (ptick_q == PhaseLast) begin
            ptick_d = '0;
            if (phase_q == 2'd2) begin
               phase_d = 2'd0;
               round_d = round_q + One;
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end else begin
            ptick_d = ptick_q + One;
         end
      end

      unique case (state_q)
         StIdle: if (bus.start) begin
            state_d = StLoad;
            port_d  = bus.port_sel;
            trap_d  = bus.trap_sel;
            abrt_d  = 1'b0;
            pre_d   = '0;
         end
         StLoad:  if (tick && cnt_q == LoadLast) state_d = StSet1;
         StSet1:  if (settle_end) state_d = StMix;
         StMix:   if (mix_end) state_d = StSet2;
         StSet2:  if (settle_end) state_d = StFlush;
         StFlush: if (tick && cnt_q == FlushLast) state_d = StSet3;
         StSet3:  if (settle_end) state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Abort (re)starts a full SET3 from a fresh prescaler phase.
      if (abort_hit) begin
         state_d = StSet3;
         abrt_d  = 1'b1;
         pre_d   = '0;
      end

      if (state_d != state_q || abort_hit) begin
         cnt_d   = '0;
         ptick_d = '0;
         phase_d = '0;
         round_d = '0;
      end

      valve_d = '1;
      case (state_d)
         StLoad: begin
            valve_d[Cb31] = 1'b0;
            if (!port_d[1]) begin
               valve_d[Cb11] = 1'b0;
               valve_d[Cb21] = 1'b0;
            end else begin
               valve_d[Cb12] = 1'b0;
               valve_d[Cb22] = 1'b0;
            end
         end
         StMix, StFlush: begin
            case (phase_d)
               2'd0:    valve_d[Cb32] = 1'b0;
               2'd1:    valve_d[Cb41] = 1'b0;
               2'd2:    valve_d[Cb42] = 1'b0;
               default: valve_d[Cb32] = 1'b1;
            endcase
            if (state_d == StFlush) begin
               valve_d[Cb33] = 1'b0;
               if (!trap_d[1]) begin
                  valve_d[Cb62] = 1'b0;
                  valve_d[Cb52] = 1'b0;
               end else begin
                  valve_d[Cb51] = 1'b0;
                  valve_d[Cb61] = 1'b0;
               end
            end
         end
         default: valve_d = '1;
      endcase

      busy_d    = (state_d != StIdle) && (state_d != StFin);
      done_d    = (state_d == StFin) && !abrt_d;
      aborted_d = (state_d == StFin) && abrt_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         pre_q     <= '0;
         cnt_q     <= '0;
         ptick_q   <= '0;
         round_q   <= '0;
         phase_q   <= '0;
         port_q    <= '0;
         trap_q    <= '0;
         abrt_q    <= 1'b0;
         valve_q   <= '1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         cnt_q     <= cnt_d;
         ptick_q   <= ptick_d;
         round_q   <= round_d;
         phase_q   <= phase_d;
         port_q    <= port_d;
         trap_q    <= trap_d;
         abrt_q    <= abrt_d;
         valve_q   <= valve_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.aborted = aborted_q;
   assign bus.cb1_1   = valve_q[Cb11];
   assign bus.cb1_2   = valve_q[Cb12];
   assign bus.cb2_1   = valve_q[Cb21];
   assign bus.cb2_2   = valve_q[Cb22];
   assign bus.cb3_1   = valve_q[Cb31];
   assign bus.cb3_2   = valve_q[Cb32];
   assign bus.cb3_3   = valve_q[Cb33];
   assign bus.cb4_1   = valve_q[Cb41];
   assign bus.cb4_2   = valve_q[Cb42];
   assign bus.cb5_1   = valve_q[Cb51];
   assign bus.cb5_2   = valve_q[Cb52];
   assign bus.cb6_1   = valve_q[Cb61];
   assign bus.cb6_2   = valve_q[Cb62];

endmodule

// File: tb/tb_rotary_valve_seq.sv
// Bench for rotary_valve_seq: two instances (TICK_DIV 1 and 3) share stimulus and are checked
// every cycle against a timeline model computed from step lengths in ticks.
module tb_rotary_valve_seq;

   localparam int L  = 4;
   localparam int PT = 2;
   localparam int MR = 2;
   localparam int F  = 3;
   localparam int S  = 1;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        aborted;
      logic [12:0] v;
   } obs_t;

   typedef struct packed {
      bit         run;
      bit         ab;
      int         s;
      int         a;
      logic [1:0] port;
      logic [1:0] trap;
   } model_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   done_a, done_b, abt_a, abt_b;
   model_t m_a, m_b;

   rotary_valve_seq_if bus_a ();
   rotary_valve_seq_if bus_b ();

   rotary_valve_seq #(
      .TICK_DIV(1), .LOAD_TICKS(L), .PHASE_TICKS(PT), .MIX_ROUNDS(MR),
      .FLUSH_TICKS(F), .SETTLE_TICKS(S), .CNT_W(16)
   ) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );

   rotary_valve_seq #(
      .TICK_DIV(3), .LOAD_TICKS(L), .PHASE_TICKS(PT), .MIX_ROUNDS(MR),
      .FLUSH_TICKS(F), .SETTLE_TICKS(S), .CNT_W(16)
   ) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // seg: 0 all closed, 1 load, 2 mix, 3 flush
   function automatic logic [12:0] valves(int seg, int ph, logic [1:0] port, logic [1:0] trap);
      logic [2:0] pat [3];
      logic cb1_1, cb1_2, cb2_1, cb2_2, cb3_1, cb3_2, cb3_3, cb4_1, cb4_2;
      logic cb5_1, cb5_2, cb6_1, cb6_2;
      pat[0] = 3'b110;
      pat[1] = 3'b011;
      pat[2] = 3'b101;
      {cb1_1, cb1_2, cb2_1, cb2_2, cb3_1, cb3_2, cb3_3} = 7'h7f;
      {cb4_1, cb4_2, cb5_1, cb5_2, cb6_1, cb6_2} = 6'h3f;
      if (seg == 1) begin
         cb3_1 = 1'b0;
         if (port < 2) {cb1_1, cb2_1} = 2'b00;
         else          {cb1_2, cb2_2} = 2'b00;
      end
      if (seg >= 2) {cb4_1, cb4_2, cb3_2} = pat[ph];
      if (seg == 3) begin
         cb3_3 = 1'b0;
         if (trap < 2) {cb6_2, cb5_2} = 2'b00;
         else          {cb5_1, cb6_1} = 2'b00;
      end
      return {cb1_1, cb1_2, cb2_1, cb2_2, cb3_1, cb3_2, cb3_3, cb4_1, cb4_2,
              cb5_1, cb5_2, cb6_1, cb6_2};
   endfunction

   function automatic obs_t expect_at(model_t m, int c, int td);
      obs_t o;
      int t, k, b1, b2, b3, b4, b5, b6;
      o  = '0;
      o.v = '1;
      b1 = L;
      b2 = b1 + S;
      b3 = b2 + 3 * PT * MR;
      b4 = b3 + S;
      b5 = b4 + F;
      b6 = b5 + S;
      if (m.ab) begin
         t = c - m.a - 1;
         if (t < S * td) o.busy = 1'b1;
         else if (t == S * td) o.aborted = 1'b1;
      end else if (m.run) begin
         t = c - m.s - 1;
         k = t / td;
         if (t == b6 * td) o.done = 1'b1;
         else if (t < b6 * td) begin
            o.busy = 1'b1;
            if (k < b1) o.v = valves(1, 0, m.port, m.trap);
            else if (k >= b2 && k < b3) o.v = valves(2, ((k - b2) / PT) % 3, m.port, m.trap);
            else if (k >= b4 && k < b5) o.v = valves(3, ((k - b4) / PT) % 3, m.port, m.trap);
         end
      end
      return o;
   endfunction

   function automatic model_t model_next(model_t m, obs_t e, int c, logic st, logic ab,
                                         logic [1:0] ps, logic [1:0] ts);
      model_t n;
      n = m;
      if (!(e.busy || e.done || e.aborted) && st) begin
         n.run  = 1'b1;
         n.ab   = 1'b0;
         n.s    = c;
         n.port = ps;
         n.trap = ts;
      end else if (e.busy && ab) begin
         n.ab = 1'b1;
         n.a  = c;
      end
      return n;
   endfunction

   task automatic check_obs(input string pfx, input obs_t act, input obs_t exp);
      check_val({pfx, "_busy"}, 32'(act.busy), 32'(exp.busy));
      check_val({pfx, "_done"}, 32'(act.done), 32'(exp.done));
      check_val({pfx, "_aborted"}, 32'(act.aborted), 32'(exp.aborted));
      check_val({pfx, "_valves"}, 32'(act.v), 32'(exp.v));
   endtask

   // Entered just after a negedge: check this cycle, drive inputs, advance one clock.
   task automatic step_cycle(input logic st, input logic ab, input logic [1:0] ps,
                             input logic [1:0] ts);
      obs_t act_a, act_b, ea, eb;
      ea    = expect_at(m_a, cyc, 1);
      eb    = expect_at(m_b, cyc, 3);
      act_a = {bus_a.busy, bus_a.done, bus_a.aborted, bus_a.cb1_1, bus_a.cb1_2, bus_a.cb2_1,
               bus_a.cb2_2, bus_a.cb3_1, bus_a.cb3_2, bus_a.cb3_3, bus_a.cb4_1, bus_a.cb4_2,
               bus_a.cb5_1, bus_a.cb5_2, bus_a.cb6_1, bus_a.cb6_2};
      act_b = {bus_b.busy, bus_b.done, bus_b.aborted, bus_b.cb1_1, bus_b.cb1_2, bus_b.cb2_1,
               bus_b.cb2_2, bus_b.cb3_1, bus_b.cb3_2, bus_b.cb3_3, bus_b.cb4_1, bus_b.cb4_2,
               bus_b.cb5_1, bus_b.cb5_2, bus_b.cb6_1, bus_b.cb6_2};
      check_obs("a", act_a, ea);
      check_obs("b", act_b, eb);
      if (act_a.done) done_a = cyc;
      if (act_b.done) done_b = cyc;
      if (act_a.aborted) abt_a = cyc;
      if (act_b.aborted) abt_b = cyc;
      bus_a.start = st;  bus_a.abort = ab;  bus_a.port_sel = ps;  bus_a.trap_sel = ts;
      bus_b.start = st;  bus_b.abort = ab;  bus_b.port_sel = ps;  bus_b.trap_sel = ts;
      @(posedge clk);
      m_a = model_next(m_a, ea, cyc, st, ab, ps, ts);
      m_b = model_next(m_b, eb, cyc, st, ab, ps, ts);
      cyc++;
      @(negedge clk);
   endtask

   // Reset pulse placed mid-cycle, checked before the next clock edge.
   task automatic async_reset();
      bus_a.start = 1'b0;  bus_a.abort = 1'b0;
      bus_b.start = 1'b0;  bus_b.abort = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_val("rst_a_busy", 32'(bus_a.busy), 32'd0);
      check_val("rst_b_busy", 32'(bus_b.busy), 32'd0);
      check_val("rst_a_pulse", 32'({bus_a.done, bus_a.aborted}), 32'd0);
      check_val("rst_a_valves", 32'({bus_a.cb1_1, bus_a.cb1_2, bus_a.cb2_1, bus_a.cb2_2,
                bus_a.cb3_1, bus_a.cb3_2, bus_a.cb3_3, bus_a.cb4_1, bus_a.cb4_2, bus_a.cb5_1,
                bus_a.cb5_2, bus_a.cb6_1, bus_a.cb6_2}), 32'h1fff);
      check_val("rst_b_valves", 32'({bus_b.cb1_1, bus_b.cb1_2, bus_b.cb2_1, bus_b.cb2_2,
                bus_b.cb3_1, bus_b.cb3_2, bus_b.cb3_3, bus_b.cb4_1, bus_b.cb4_2, bus_b.cb5_1,
                bus_b.cb5_2, bus_b.cb6_1, bus_b.cb6_2}), 32'h1fff);
      @(negedge clk);
      rst = 1'b0;
      m_a = '0;
      m_b = '0;
      cyc++;
   endtask

   initial begin
      int s;
      m_a = '0;
      m_b = '0;
      done_a = -1;  done_b = -1;  abt_a = -1;  abt_b = -1;
      bus_a.start = 1'b0;  bus_a.abort = 1'b0;  bus_a.port_sel = '0;  bus_a.trap_sel = '0;
      bus_b.start = 1'b0;  bus_b.abort = 1'b0;  bus_b.port_sel = '0;  bus_b.trap_sel = '0;

      // Reset state, held for a few cycles.
      @(negedge clk);
      repeat (3) step_cycle(1'b0, 1'b0, 2'd0, 2'd0);
      rst = 1'b0;
      repeat (2) step_cycle(1'b0, 1'b0, 2'd0, 2'd0);

      // Nominal run with start re-pulsed at +3 and +23, selects wiggled mid-run.
      s = cyc;
      step_cycle(1'b1, 1'b0, 2'd2, 2'd1);
      for (int i = 1; i < 72; i++)
         step_cycle(i == 3 || i == 23, 1'b0, 2'(i), 2'(i + 1));
      check_val("nom_done_a", 32'(done_a - s), 32'd23);
      check_val("nom_done_b", 32'(done_b - s), 32'd67);

      // Abort at +10.
      done_a = -1;  done_b = -1;
      s = cyc;
      step_cycle(1'b1, 1'b0, 2'd1, 2'd3);
      for (int i = 1; i < 20; i++) step_cycle(1'b0, i == 10, 2'd1, 2'd3);
      check_val("abort_pulse_a", 32'(abt_a - s), 32'd12);
      check_val("abort_pulse_b", 32'(abt_b - s), 32'd14);
      check_val("abort_no_done_a", 32'(done_a), 32'hffff_ffff);
      check_val("abort_no_done_b", 32'(done_b), 32'hffff_ffff);

      // Asynchronous reset at +8, then no pulse may follow.
      done_a = -1;  done_b = -1;  abt_a = -1;  abt_b = -1;
      step_cycle(1'b1, 1'b0, 2'd3, 2'd0);
      for (int i = 1; i < 8; i++) step_cycle(1'b0, 1'b0, 2'd3, 2'd0);
      async_reset();
      for (int i = 0; i < 75; i++) step_cycle(1'b0, 1'b0, 2'd0, 2'd0);
      check_val("rst_no_done", 32'(done_a + done_b), 32'hffff_fffe);
      check_val("rst_no_abort", 32'(abt_a + abt_b), 32'hffff_fffe);

      // Port / trap sweep.
      for (int p = 0; p < 4; p++) begin
         for (int t = 0; t < 4; t++) begin
            step_cycle(1'b1, 1'b0, 2'(p), 2'(t));
            for (int i = 1; i < 70; i++) step_cycle(1'b0, 1'b0, 2'(3 - p), 2'(3 - t));
         end
      end

      // Random traffic with occasional aborts and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) == 0) async_reset();
         step_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 79) == 0,
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
